// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-cathode digits that
// share one hex-to-seven-segment decoder and one segment bus. Each digit has
// a shadow (host-written) and an active (displayed) 6-bit register holding
// {on, dp, hex[3:0]}. Every digit slot lasts REFRESH_DIV cycles. The first
// BLANK_CYCLES cycles of a slot have all digits off, and the rest drive the
// slot's digit. Shadow contents move to the active bank only at a frame
// boundary, so a partially written display is never shown.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   wr_en        write strobe into the shadow bank
//   wr_addr      digit index for the write; indices >= NUM_DIGITS are dropped
//   wr_data      {on, dp, hex[3:0]}
//   commit_req   pulse; asks for a shadow->active copy at the next frame boundary
//   seg_nibble   registered hex value for the decoder
//   seg_dp       registered decimal point for the current digit
//   digit_en     one-hot-or-zero digit enables, active-high
//   frame_tick   one-cycle pulse in the first cycle of each new frame
//   commit_done  one-cycle pulse in the first cycle of a frame that applied a commit
//   dbg_show     FSM state for observation (1 = SHOW, 0 = BLANK)
//
// Host interface: wr_en and commit_req have no ready. Both are accepted on
// every cycle they are high. Back-to-back commit_req pulses collapse into a
// single pending request.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [5:0]                    wr_data,
  input  logic                          commit_req,
  output logic [3:0]                    seg_nibble,
  output logic                          seg_dp,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_tick,
  output logic                          commit_done,
  output logic                          dbg_show
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            pending_q, pending_d;
  logic [5:0]      shadow_q [NUM_DIGITS];
  logic [5:0]      active_q [NUM_DIGITS];
  logic [3:0]      seg_nibble_q;
  logic            seg_dp_q;
  logic            frame_tick_q;
  logic            commit_done_q;

  logic            slot_end;
  logic            enter_blank;
  logic            boundary;
  logic            commit_now;
  logic            wr_hit;
  logic [5:0]      next_val;

  // Next-state logic. The slot counter runs 0..REFRESH_DIV-1 across both
  // states, so BLANK ends at a fixed count and SHOW ends when the slot ends.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slot_end    = (cnt_q == SLOT_LAST);
    cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
    enter_blank = 1'b0;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (slot_end) begin
          state_d     = S_BLANK;
          enter_blank = 1'b1;
          idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
      end
    endcase

    boundary   = enter_blank && (idx_q == IDX_LAST);
    commit_now = boundary && pending_q;
    // A request arriving on the boundary cycle is kept for the next frame.
    pending_d  = commit_req | (pending_q & ~boundary);
    wr_hit     = wr_en && (int'(wr_addr) < NUM_DIGITS);
    // The value loaded for the new slot must already reflect a commit that
    // happens on this same edge, so read the shadow bank directly in that case.
    next_val   = commit_now ? shadow_q[idx_d] : active_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      seg_nibble_q  <= '0;
      seg_dp_q      <= 1'b0;
      frame_tick_q  <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      frame_tick_q  <= boundary;
      commit_done_q <= commit_now;
      // Nonblocking copy takes the pre-write shadow, so a write on the commit
      // cycle remains in the shadow bank only.
      if (commit_now) begin
        active_q <= shadow_q;
      end
      if (wr_hit) begin
        shadow_q[wr_addr] <= wr_data;
      end
      // The segment value is latched when BLANK starts, which gives the
      // decoder the whole blank window to settle.
      if (enter_blank) begin
        seg_nibble_q <= next_val[3:0];
        seg_dp_q     <= next_val[4];
      end
    end
  end

  always_comb begin
    digit_en = '0;
    if (state_q == S_SHOW) begin
      digit_en[idx_q] = active_q[idx_q][5];
    end
  end

  assign seg_nibble  = seg_nibble_q;
  assign seg_dp      = seg_dp_q;
  assign frame_tick  = frame_tick_q;
  assign commit_done = commit_done_q;
  assign dbg_show    = (state_q == S_SHOW);

endmodule
